// File: rtl/ip_fifo_pkg.sv
// Shared types and elaboration helpers for the ip_fifo family.
package ip_fifo_pkg;

  // Read-port behaviour: registered read or first-word-fall-through.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned PTR_W(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Power-of-two check for depth (at least 2 entries).
  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Threshold range checks: almost_full in 1..depth, almost_empty in 0..depth-1.
  function automatic bit levels_ok(input int unsigned depth,
                                   input int unsigned af_level,
                                   input int unsigned ae_level);
    return (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/ip_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
module ip_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store wdata at waddr on enabled edges.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: combinational lookup.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/ip_sync_fifo.sv
// Single-clock FIFO with thresholds, occupancy count, sticky error flags,
// synchronous flush and selectable FWFT read mode.
module ip_sync_fifo
  import ip_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = PTR_W(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam fifo_mode_e  MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  if (!depth_ok(DEPTH) || !levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $fatal(1, "ip_sync_fifo: DEPTH must be a power of two >= 2, AF_LEVEL in 1..DEPTH, AE_LEVEL in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] rd_data;

  // Occupancy is the pointer distance; the wrap bit makes DEPTH distinguishable from 0.
  always_comb begin
    count        = wr_ptr - rd_ptr;
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
    wr_acc       = wr_en && !full && !flush;
    rd_acc       = rd_en && !empty && !flush;
  end

  // Pointer advance and sticky error flags; flush overrides any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  ip_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Head entry is presented directly; valid whenever not empty.
    always_comb begin
      dout = rd_data;
    end
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;

    // Registered read data: updates only on an accepted read, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= rd_data;
    end

    always_comb begin
      dout = dout_q;
    end
  end

endmodule

// File: tb/tb_ip_sync_fifo.sv
// Self-checking bench for ip_sync_fifo: one registered-read and one FWFT
// instance share stimulus and are checked against a queue-based model.
module tb_ip_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;

  logic [7:0] dout_s, dout_f;
  logic       full_s, empty_s, af_s, ae_s, ov_s, un_s;
  logic       full_f, empty_f, af_f, ae_f, ov_f, un_f;
  logic [2:0] cnt_s, cnt_f;

  int vectors = 0;
  int errs    = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ov;
  bit         m_un;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  ip_sync_fifo #(
    .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)
  ) dut_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(cnt_s), .overflow(ov_s), .underflow(un_s)
  );

  ip_sync_fifo #(
    .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ov_f), .underflow(un_f)
  );

  task automatic model_reset();
    q.delete();
    m_ov   = 1'b0;
    m_un   = 1'b0;
    m_dout = 8'h00;
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, settle 1 time unit.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f);
    bit wa, ra;
    wr_en = w; din = d; rd_en = r; flush = f;
    @(posedge clk);
    if (f) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      wa = w && (q.size() < 4);
      ra = r && (q.size() > 0);
      if (w && q.size() == 4) m_ov = 1'b1;
      if (r && q.size() == 0) m_un = 1'b1;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    model_reset();
    #3;
    vectors++;
    if ({empty_s, ae_s, full_s, af_s, ov_s, un_s} !== 6'b110000) begin
      errs++; $display("FAIL reset_flags: got %b want 110000", {empty_s, ae_s, full_s, af_s, ov_s, un_s});
    end
    vectors++;
    if (cnt_s !== 3'd0 || dout_s !== 8'h00) begin
      errs++; $display("FAIL reset_count_dout: got count=%0d dout=%h want 0 00", cnt_s, dout_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      vectors++;
      if (cnt_s !== 3'(i) || af_s !== (i >= 3) || full_s !== (i == 4)) begin
        errs++; $display("FAIL fill_%0d: got count=%0d af=%b full=%b want %0d %b %b",
                         i, cnt_s, af_s, full_s, i, (i >= 3), (i == 4));
      end
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (dout_s !== 8'(i) || empty_s !== (i == 4)) begin
        errs++; $display("FAIL drain_%0d: got dout=%h empty=%b want %h %b", i, dout_s, empty_s, 8'(i), (i == 4));
      end
    end
  endtask

  task automatic test_overflow_underflow();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    vectors++;
    if (cnt_s !== 3'd4 || ov_s !== 1'b1) begin
      errs++; $display("FAIL overflow: got count=%0d ov=%b want 4 1", cnt_s, ov_s);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (dout_s !== 8'(i)) begin
        errs++; $display("FAIL ovf_read_%0d: got %h want %h", i, dout_s, 8'(i));
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (un_s !== 1'b1 || dout_s !== 8'h04 || cnt_s !== 3'd0 || ov_s !== 1'b1) begin
      errs++; $display("FAIL underflow: got un=%b dout=%h count=%0d ov=%b want 1 04 0 1", un_s, dout_s, cnt_s, ov_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_rd [6];
    exp_rd[0] = 8'h20; exp_rd[1] = 8'h21; exp_rd[2] = 8'h10;
    exp_rd[3] = 8'h11; exp_rd[4] = 8'h12; exp_rd[5] = 8'h13;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
      vectors++;
      if (cnt_s !== 3'd2 || dout_s !== exp_rd[i] || dout_s !== m_dout) begin
        errs++; $display("FAIL b2b_%0d: got count=%0d dout=%h want 2 %h", i, cnt_s, dout_s, exp_rd[i]);
      end
    end
    vectors++;
    if (dout_f !== 8'h14) begin
      errs++; $display("FAIL b2b_head: got %h want 14", dout_f);
    end
  endtask

  task automatic test_fwft();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    vectors++;
    if (empty_f !== 1'b0 || dout_f !== 8'hA5) begin
      errs++; $display("FAIL fwft_show: got empty=%b dout=%h want 0 a5", empty_f, dout_f);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (empty_f !== 1'b1 || cnt_f !== 3'd0) begin
      errs++; $display("FAIL fwft_pop: got empty=%b count=%0d want 1 0", empty_f, cnt_f);
    end
  endtask

  task automatic test_flush_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (cnt_s !== 3'd3 || ov_s !== 1'b1) begin
      errs++; $display("FAIL flush_pre: got count=%0d ov=%b want 3 1", cnt_s, ov_s);
    end
    step(1'b1, 8'h77, 1'b0, 1'b1);
    vectors++;
    if (cnt_s !== 3'd0 || empty_s !== 1'b1 || ov_s !== 1'b0 || dout_s !== 8'h01) begin
      errs++; $display("FAIL flush: got count=%0d empty=%b ov=%b dout=%h want 0 1 0 01", cnt_s, empty_s, ov_s, dout_s);
    end
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    vectors++;
    if (cnt_s !== 3'd2 || dout_f !== 8'h31) begin
      errs++; $display("FAIL refill: got count=%0d head=%h want 2 31", cnt_s, dout_f);
    end
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (cnt_s !== 3'd0 || empty_s !== 1'b1 || dout_s !== 8'h00 || cnt_f !== 3'd0) begin
      errs++; $display("FAIL async_rst: got count=%0d empty=%b dout=%h countf=%0d want 0 1 00 0", cnt_s, empty_s, dout_s, cnt_f);
    end
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    bit         w, r, f;
    logic [7:0] d;
    logic [5:0] exp_flags;
    for (int n = 0; n < 400; n++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 31) == 0);
      d = 8'($urandom);
      step(w, d, r, f);
      exp_flags = {q.size() == 4, q.size() == 0, q.size() >= 3, q.size() <= 1, m_ov, m_un};
      vectors++;
      if ({full_s, empty_s, af_s, ae_s, ov_s, un_s} !== exp_flags || cnt_s !== 3'(q.size())) begin
        errs++; $display("FAIL rand_std_status[%0d]: got flags=%b count=%0d want %b %0d",
                         n, {full_s, empty_s, af_s, ae_s, ov_s, un_s}, cnt_s, exp_flags, q.size());
      end
      vectors++;
      if ({full_f, empty_f, af_f, ae_f, ov_f, un_f} !== exp_flags || cnt_f !== 3'(q.size())) begin
        errs++; $display("FAIL rand_fwft_status[%0d]: got flags=%b count=%0d want %b %0d",
                         n, {full_f, empty_f, af_f, ae_f, ov_f, un_f}, cnt_f, exp_flags, q.size());
      end
      vectors++;
      if (dout_s !== m_dout) begin
        errs++; $display("FAIL rand_std_dout[%0d]: got %h want %h", n, dout_s, m_dout);
      end
      if (q.size() > 0) begin
        vectors++;
        if (dout_f !== q[0]) begin
          errs++; $display("FAIL rand_fwft_dout[%0d]: got %h want %h", n, dout_f, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_back_to_back();
    test_fwft();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
